pipe_stage_skid: RTL

- Parametrised successor to the fixed-width inter-stage pipeline registers (ID->EXE and similar). It carries a control bundle and a data bundle between two pipeline stages.
- Adds a valid/ready handshake with a 2-entry skid buffer, so back-pressure does not create a combinational ready path.
- Adds flush (bubble insertion) and a saturating back-pressure stall counter.
- Instantiated once per stage boundary (IF/ID, ID/EXE, EXE/MEM, MEM/WB), with widths set per boundary.

---
 rtl/pipe_stage_skid_pkg.sv | 33 +++
 rtl/pipe_stage_skid_entry.sv | 34 +++
 rtl/pipe_stage_skid.sv | 112 +++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared widths and ID/EXE field layout for the inter-stage pipeline registers.
package pipe_pkg;

  localparam int unsigned IFID_CTRL_W   = 1;
  localparam int unsigned IFID_DATA_W   = 64;   // pc 32 + instr 32
  localparam int unsigned IDEXE_CTRL_W  = 9;    // WB 2 + MEM 2 + EXE 5
  localparam int unsigned IDEXE_DATA_W  = 117;  // imm + rs1 + rs2 + Rs/Rt/Rd + opcode
  localparam int unsigned EXEMEM_CTRL_W = 4;    // WB 2 + MEM 2
  localparam int unsigned EXEMEM_DATA_W = 69;   // alu 32 + rs2 32 + rd 5
  localparam int unsigned MEMWB_CTRL_W  = 2;    // WB 2
  localparam int unsigned MEMWB_DATA_W  = 69;   // mem 32 + alu 32 + rd 5

  // ID/EXE control bundle fields
  localparam int unsigned IDEXE_EXE_LSB = 0;
  localparam int unsigned IDEXE_EXE_W   = 5;
  localparam int unsigned IDEXE_MEM_LSB = 5;
  localparam int unsigned IDEXE_MEM_W   = 2;
  localparam int unsigned IDEXE_WB_LSB  = 7;
  localparam int unsigned IDEXE_WB_W    = 2;

  // ID/EXE data bundle fields
  localparam int unsigned IDEXE_OPCODE_LSB = 0;
  localparam int unsigned IDEXE_OPCODE_W   = 6;
  localparam int unsigned IDEXE_RD_LSB     = 6;
  localparam int unsigned IDEXE_RT_LSB     = 11;
  localparam int unsigned IDEXE_RS_LSB     = 16;
  localparam int unsigned IDEXE_REG_W      = 5;
  localparam int unsigned IDEXE_RD2_LSB    = 21;
  localparam int unsigned IDEXE_RD1_LSB    = 53;
  localparam int unsigned IDEXE_IMM_LSB    = 85;
  localparam int unsigned IDEXE_WORD_W     = 32;

endpackage

// File: rtl/pipe_stage_skid_entry.sv
// One pipeline entry: valid + ctrl + data. clear kills the beat and zeroes ctrl.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = IDEXE_CTRL_W,
  parameter int unsigned DATA_W = IDEXE_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
      q_data  <= '0;
    end else if (clear) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
    end else if (load) begin
      q_valid <= 1'b1;
      q_ctrl  <= d_ctrl;
      q_data  <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage register with valid/ready handshake, optional skid entry,
// flush bubble insertion and a saturating back-pressure counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W  = IDEXE_CTRL_W,
  parameter int unsigned DATA_W  = IDEXE_DATA_W,
  parameter bit          SKID_EN = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              in_fire;
  logic              main_free;
  logic              main_load;
  logic              main_clear;
  logic              skid_load;
  logic              skid_clear;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic [DATA_W-1:0] main_d_data;

  assign out_valid = main_valid;
  assign in_fire   = in_valid & in_ready;
  assign main_free = ~main_valid | out_ready;

  // Flush dominates; otherwise a free main slot takes the skid beat first,
  // then the incoming beat, else empties. A stalled main parks input in skid.
  always_comb begin
    main_load   = 1'b0;
    main_clear  = 1'b0;
    skid_load   = 1'b0;
    skid_clear  = 1'b0;
    main_d_ctrl = skid_valid ? skid_ctrl : in_ctrl;
    main_d_data = skid_valid ? skid_data : in_data;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (main_free) begin
      if (skid_valid) begin
        main_load  = 1'b1;
        skid_clear = 1'b1;
      end else if (in_fire) begin
        main_load  = 1'b1;
      end else begin
        main_clear = 1'b1;
      end
    end else if (in_fire) begin
      skid_load = 1'b1;
    end
  end

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load    (main_load),
    .clear   (main_clear),
    .d_ctrl  (main_d_ctrl),
    .d_data  (main_d_data),
    .q_valid (main_valid),
    .q_ctrl  (out_ctrl),
    .q_data  (out_data)
  );

  if (SKID_EN) begin : g_skid
    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .load    (skid_load),
      .clear   (skid_clear),
      .d_ctrl  (in_ctrl),
      .d_data  (in_data),
      .q_valid (skid_valid),
      .q_ctrl  (skid_ctrl),
      .q_data  (skid_data)
    );
    assign in_ready = ~skid_valid;
  end else begin : g_noskid
    assign skid_valid = 1'b0;
    assign skid_ctrl  = '0;
    assign skid_data  = '0;
    assign in_ready   = ~main_valid | out_ready;
  end

  // Saturating count of cycles spent stalled by downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stat_clr) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
